// File: rtl/debug_frame_tx.sv
// Purpose : snapshot a wide debug bus on capture and send it to the UART as a framed byte stream:
//           A5 | LEN_HI | LEN_LO | payload[0..N-1] | CSUM. CSUM makes the bytes after the header sum to 0 mod 256.
// Latency : LOAD, ISSUE, WAIT_ACK and NEXT each take one cycle per byte, on top of the UART's own busy time.
// Backpressure: a byte is strobed only while i_tx_busy is low. A capture that arrives while not IDLE
//           is dropped and sets the sticky o_dropped flag.
// Ports   : i_clock, i_reset (sync, active-high), i_capture, i_snap_data (byte 0 = MSBs), i_tx_busy
//           o_w_data, o_wr_uart, o_busy, o_frame_done, o_dropped
module debug_frame_tx #(
    parameter int          SNAP_BYTES = 217,
    parameter logic [7:0]  HDR_BYTE   = 8'hA5
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_capture,
    input  logic [SNAP_BYTES*8-1:0] i_snap_data,
    input  logic                    i_tx_busy,
    output logic [7:0]              o_w_data,
    output logic                    o_wr_uart,
    output logic                    o_busy,
    output logic                    o_frame_done,
    output logic                    o_dropped
);

    localparam int               SNAP_W   = SNAP_BYTES * 8;
    localparam int               IDX_W    = $clog2(SNAP_BYTES + 1);
    localparam logic [15:0]      LEN      = 16'(SNAP_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SNAP_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_WAIT_ACK, S_WAIT_IDLE, S_NEXT, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        F_HDR, F_LEN_HI, F_LEN_LO, F_PAY, F_CSUM
    } field_t;

    state_t             r_state;
    state_t             w_next_state;
    field_t             r_field;
    logic [IDX_W-1:0]   r_idx;
    logic [SNAP_W-1:0]  r_shadow;
    logic [7:0]         r_csum;
    logic [7:0]         r_w_data;
    logic               r_dropped;

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (i_capture) w_next_state = S_LOAD;
            S_LOAD:      w_next_state = S_ISSUE;
            S_ISSUE:     if (!i_tx_busy) w_next_state = S_WAIT_ACK;
            // Fixed one-cycle guard: the UART raises tx_busy the cycle after the strobe.
            S_WAIT_ACK:  w_next_state = S_WAIT_IDLE;
            S_WAIT_IDLE: if (!i_tx_busy) w_next_state = S_NEXT;
            S_NEXT:      w_next_state = (r_field == F_CSUM) ? S_DONE : S_LOAD;
            S_DONE:      w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        o_w_data     = r_w_data;
        o_wr_uart    = (r_state == S_ISSUE) && !i_tx_busy;
        o_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
        o_frame_done = (r_state == S_DONE);
        o_dropped    = r_dropped;
    end

    // Datapath: shadow register, field/index tracking, checksum, output byte
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_shadow  <= '0;
            r_field   <= F_HDR;
            r_idx     <= '0;
            r_csum    <= 8'd0;
            r_w_data  <= 8'd0;
            r_dropped <= 1'b0;
        end else begin
            if (i_capture && (r_state != S_IDLE)) begin
                r_dropped <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_capture) begin
                        r_shadow <= i_snap_data;
                        r_csum   <= 8'd0;
                        r_field  <= F_HDR;
                        r_idx    <= '0;
                    end
                end
                S_LOAD: begin
                    case (r_field)
                        F_HDR:    r_w_data <= HDR_BYTE;
                        F_LEN_HI: r_w_data <= LEN[15:8];
                        F_LEN_LO: r_w_data <= LEN[7:0];
                        // The shadow is shifted after each payload byte, so the current byte is always on top.
                        F_PAY:    r_w_data <= r_shadow[SNAP_W-1 -: 8];
                        F_CSUM:   r_w_data <= 8'd0 - r_csum;
                        default:  r_w_data <= HDR_BYTE;
                    endcase
                end
                S_NEXT: begin
                    if (r_field inside {F_LEN_HI, F_LEN_LO, F_PAY}) begin
                        r_csum <= r_csum + r_w_data;
                    end
                    case (r_field)
                        F_HDR:    r_field <= F_LEN_HI;
                        F_LEN_HI: r_field <= F_LEN_LO;
                        F_LEN_LO: begin
                            r_field <= F_PAY;
                            r_idx   <= '0;
                        end
                        F_PAY: begin
                            r_shadow <= r_shadow << 8;
                            if (r_idx == LAST_IDX) begin
                                r_field <= F_CSUM;
                            end else begin
                                r_idx <= r_idx + IDX_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_frame_tx.sv
// Purpose : directed bench for debug_frame_tx. Two instances are used, with 4-byte and 2-byte payloads.
// Latency : each instance has a UART model that holds tx_busy for 10 cycles after every strobe.
// Backpressure: a force input can hold tx_busy high to stall the first byte.
module tb_debug_frame_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: 4-byte payload
    logic        cap_a = 1'b0;
    logic [31:0] snap_a = '0;
    logic        txb_a, wr_a, busy_a, fd_a, drop_a, force_a = 1'b0;
    logic [7:0]  wd_a;
    int          cnt_a = 0;

    // Instance B: 2-byte payload
    logic        cap_b = 1'b0;
    logic [15:0] snap_b = '0;
    logic        txb_b, wr_b, busy_b, fd_b, drop_b;
    logic [7:0]  wd_b;
    int          cnt_b = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int fd_cnt_a = 0;
    int ovl_cnt  = 0;
    int vec      = 0;
    int fails    = 0;

    debug_frame_tx #(.SNAP_BYTES(4), .HDR_BYTE(8'hA5)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_capture(cap_a), .i_snap_data(snap_a), .i_tx_busy(txb_a),
        .o_w_data(wd_a), .o_wr_uart(wr_a), .o_busy(busy_a), .o_frame_done(fd_a), .o_dropped(drop_a)
    );

    debug_frame_tx #(.SNAP_BYTES(2), .HDR_BYTE(8'hA5)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_capture(cap_b), .i_snap_data(snap_b), .i_tx_busy(txb_b),
        .o_w_data(wd_b), .o_wr_uart(wr_b), .o_busy(busy_b), .o_frame_done(fd_b), .o_dropped(drop_b)
    );

    // UART models: tx_busy rises the cycle after the strobe and stays high for 10 cycles.
    assign txb_a = (cnt_a != 0) || force_a;
    assign txb_b = (cnt_b != 0);

    always @(posedge clk) begin
        if (rst) begin
            cnt_a <= 0;
        end else if (wr_a) begin
            cnt_a <= 10;
            qa.push_back(wd_a);
        end else if (cnt_a != 0) begin
            cnt_a <= cnt_a - 1;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            cnt_b <= 0;
        end else if (wr_b) begin
            cnt_b <= 10;
            qb.push_back(wd_b);
        end else if (cnt_b != 0) begin
            cnt_b <= cnt_b - 1;
        end
    end

    always @(negedge clk) begin
        if (fd_a) fd_cnt_a <= fd_cnt_a + 1;
        if ((wr_a && txb_a) || (wr_b && txb_b)) ovl_cnt <= ovl_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame_a(input string tag, input int base, input logic [63:0] exp);
        logic [31:0] v;
        chk({tag, "_count"}, 32'(qa.size() - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            v = (base + i < qa.size()) ? {24'd0, qa[base+i]} : 32'hFFFF_FFFF;
            chk($sformatf("%s_byte%0d", tag, i), v, {24'd0, exp[63-8*i -: 8]});
        end
    endtask

    // Waits for frame_done on A. Optionally scrambles snap_data every cycle
    // and pulses capture on iteration drop_at.
    task automatic wait_done_a(input string tag, input int budget, input bit scramble, input int drop_at);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            cap_a = (i == drop_at);
            if (scramble) snap_a = $urandom;
            @(negedge clk);
            if (fd_a) begin
                done = 1'b1;
                break;
            end
        end
        cap_a = 1'b0;
        chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    int base, fdb, sum;
    bit done;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wdata", {24'd0, wd_a}, 32'd0);
        chk("rst_wr",    {31'd0, wr_a}, 32'd0);
        chk("rst_busy",  {31'd0, busy_a}, 32'd0);
        chk("rst_fd",    {31'd0, fd_a}, 32'd0);
        chk("rst_drop",  {31'd0, drop_a}, 32'd0);
        chk("rst_b_wr",  {31'd0, wr_b}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic 4-byte frame
        base = qa.size();
        fdb = fd_cnt_a;
        snap_a = 32'h01020304;
        cap_a = 1'b1;
        wait_done_a("f1", 1000, 1'b0, -1);
        @(posedge clk);
        @(negedge clk);
        chk_frame_a("f1", base, 64'hA5_00_04_01_02_03_04_F2);
        chk("f1_fd_once", 32'(fd_cnt_a - fdb), 32'd1);
        chk("f1_busy_after", {31'd0, busy_a}, 32'd0);
        chk("f1_drop", {31'd0, drop_a}, 32'd0);

        // 2-byte frame whose checksum wraps to zero
        base = qb.size();
        snap_b = 16'hFFFF;
        @(posedge clk);
        #1 cap_b = 1'b1;
        @(posedge clk);
        #1 cap_b = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (fd_b) begin
                done = 1'b1;
                break;
            end
        end
        chk("fb_done_seen", {31'd0, done}, 32'd1);
        chk("fb_count", 32'(qb.size() - base), 32'd6);
        if (qb.size() - base == 6) begin
            chk("fb_frame", {qb[base], qb[base+1], qb[base+2], qb[base+3]}, 32'hA5_00_02_FF);
            chk("fb_tail", {16'd0, qb[base+4], qb[base+5]}, 32'h0000_FF00);
            sum = 0;
            for (int i = 1; i < 6; i++) sum += int'(qb[base+i]);
            chk("fb_host_sum", 32'(sum % 256), 32'd0);
        end

        // Scrambled snap_data, plus a capture mid-frame that must be dropped
        base = qa.size();
        snap_a = 32'hDEADBEEF;
        cap_a = 1'b1;
        wait_done_a("f2", 1000, 1'b1, 40);
        chk_frame_a("f2", base, 64'hA5_00_04_DE_AD_BE_EF_C4);
        chk("f2_drop", {31'd0, drop_a}, 32'd1);

        // A capture in the first IDLE cycle after DONE is accepted
        @(posedge clk);
        #1;
        base = qa.size();
        snap_a = 32'h80FF0110;
        cap_a = 1'b1;
        @(posedge clk);
        #1 cap_a = 1'b0;
        @(negedge clk);
        chk("f3_busy_start", {31'd0, busy_a}, 32'd1);
        wait_done_a("f3", 1000, 1'b0, -1);
        chk_frame_a("f3", base, 64'hA5_00_04_80_FF_01_10_6C);
        chk("f3_drop_sticky", {31'd0, drop_a}, 32'd1);

        // tx_busy held high for 50 cycles before the first byte
        @(posedge clk);
        #1;
        force_a = 1'b1;
        base = qa.size();
        snap_a = 32'h01020304;
        cap_a = 1'b1;
        @(posedge clk);
        #1 cap_a = 1'b0;
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("f4_withheld", 32'(qa.size() - base), 32'd0);
        chk("f4_busy", {31'd0, busy_a}, 32'd1);
        force_a = 1'b0;
        wait_done_a("f4", 1000, 1'b0, -1);
        chk_frame_a("f4", base, 64'hA5_00_04_01_02_03_04_F2);

        // Reset after the third byte aborts the frame
        @(posedge clk);
        #1;
        base = qa.size();
        snap_a = 32'h11223344;
        cap_a = 1'b1;
        @(posedge clk);
        #1 cap_a = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (qa.size() - base >= 3) begin
                done = 1'b1;
                break;
            end
        end
        chk("f5_third_byte", {31'd0, done}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("f5_rst_wdata", {24'd0, wd_a}, 32'd0);
        chk("f5_rst_wr",    {31'd0, wr_a}, 32'd0);
        chk("f5_rst_busy",  {31'd0, busy_a}, 32'd0);
        chk("f5_rst_fd",    {31'd0, fd_a}, 32'd0);
        chk("f5_rst_drop",  {31'd0, drop_a}, 32'd0);
        repeat (40) @(negedge clk);
        chk("f5_no_more_wr", 32'(qa.size() - base), 32'd3);
        chk("f5_idle", {31'd0, busy_a}, 32'd0);

        // Fresh frame after the abort
        @(posedge clk);
        #1;
        base = qa.size();
        snap_a = 32'hA1B2C3D4;
        cap_a = 1'b1;
        wait_done_a("f6", 1000, 1'b0, -1);
        chk_frame_a("f6", base, 64'hA5_00_04_A1_B2_C3_D4_12);

        @(negedge clk);
        chk("no_strobe_while_busy", 32'(ovl_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
        $finish;
    end

endmodule

// File: doc/debug_frame_tx.md
Name: debug_frame_tx

Overview:
- Captures a wide debug snapshot of the pipeline state (PC, registers, latch contents, memories) on request.
- Serialises it into a framed, checksummed byte stream and feeds the UART transmitter one byte at a time using a write-strobe / busy handshake.
- Sits between the debug bus and the UART TX path, downstream of the pipeline/debug bus and upstream of the UART.
- Adds a header, a length field and a checksum so the host can validate each dump.

Parameters:
- SNAP_BYTES, 217, payload length in bytes. Snapshot width is SNAP_BYTES*8. Range 1..65535.
- HDR_BYTE, 8'hA5, frame start marker.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- capture  in  1  single-cycle request to snapshot and send
- snap_data  in  SNAP_BYTES*8  debug bus; byte 0 is bits [SNAP_BYTES*8-1 -: 8] (MSB first)
- tx_busy  in  1  UART transmitter busy; asserts the cycle after wr_uart and stays high until the byte is shifted out
- w_data  out  8  byte to UART
- wr_uart  out  1  one-cycle write strobe to UART
- busy  out  1  high from capture acceptance until frame_done
- frame_done  out  1  one-cycle pulse after the last byte is fully transmitted
- dropped  out  1  sticky flag: a capture arrived while busy

Behaviour:
- Reset values: w_data=0, wr_uart=0, busy=0, frame_done=0, dropped=0. Reset also clears the FSM to IDLE, the byte index and the checksum.
- Reset mid-frame aborts immediately. No further wr_uart is issued; the partially sent frame is not resumed.
- Frame layout, in order:
  - HDR_BYTE
  - LEN_HI = SNAP_BYTES[15:8]
  - LEN_LO = SNAP_BYTES[7:0]
  - payload bytes 0..SNAP_BYTES-1
  - CSUM
- CSUM = (0 - (LEN_HI + LEN_LO + sum of payload)) mod 256, an 8-bit wrap-around sum. The sum of all bytes after the header, including CSUM, is 0 mod 256. The header is excluded.
- The snapshot is registered into an internal shadow register in the cycle capture is sampled in IDLE. Later changes on snap_data do not affect the frame in flight.
- FSM states: IDLE, LOAD, ISSUE, WAIT_ACK, WAIT_IDLE, NEXT, DONE.
  - IDLE: busy=0. If capture=1, latch snap_data, clear the checksum, set field index to HDR, go to LOAD (busy=1 from the next cycle).
  - LOAD: select the byte for the current field (header, lengths, shadow payload byte[idx], or checksum) into w_data, go to ISSUE.
  - ISSUE: if tx_busy=0, assert wr_uart for exactly one cycle with w_data stable and go to WAIT_ACK. Otherwise stay.
  - WAIT_ACK: one guard cycle, so that tx_busy has risen; go to WAIT_IDLE.
  - WAIT_IDLE: stay while tx_busy=1. When tx_busy=0, go to NEXT.
  - NEXT:
    - Accumulate the sent byte into the checksum unless it is the header or the checksum itself.
    - Advance the field: HDR→LEN_HI→LEN_LO→PAYLOAD (idx=0)→ PAYLOAD idx+1 … → CSUM after idx=SNAP_BYTES-1 → DONE after CSUM.
    - Otherwise go to LOAD.
  - DONE: pulse frame_done for one cycle, deassert busy, go to IDLE.
- w_data holds its value between strobes. wr_uart is never asserted while tx_busy=1, and never twice for the same byte.
- Throughput: at least 4 clocks per byte of overhead beyond the UART's busy time.
- A capture in any state other than IDLE is ignored and sets dropped=1. dropped clears only on reset.
- A capture coinciding with the DONE cycle is also dropped. A capture in the first IDLE cycle after DONE is accepted.
- The payload index counter is ceil(log2(SNAP_BYTES+1)) bits wide, with no wrap in legal operation.
- If tx_busy never rises after wr_uart, the FSM proceeds anyway: WAIT_ACK is fixed-length and WAIT_IDLE sees tx_busy=0.

Test Plan:
- SNAP_BYTES=4, snap_data=32'h01020304, UART model busy 10 cycles/byte, capture pulse → bytes A5 00 04 01 02 03 04 F2 in order. Exactly 8 wr_uart pulses, frame_done once, busy low afterwards.
- SNAP_BYTES=2, snap_data=16'hFFFF → A5 00 02 FF FF 00 (checksum wrap). Host-side sum of bytes 2..6 mod 256 = 0.
- Change snap_data every cycle during the frame → payload equals the value present at capture.
- Second capture mid-frame → frame unaffected, dropped=1. A capture 1 cycle after frame_done starts a new frame with dropped still 1.
- Hold tx_busy=1 for 50 cycles before the first byte → wr_uart withheld until tx_busy=0. No strobe overlaps tx_busy=1 at any point (assertion).
- Assert reset after the 3rd byte → outputs return to reset values next cycle, no further wr_uart. A fresh capture sends a full correct frame.
